// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding selects, load-use stall and stall counter for the 5-stage pipe
module fwd_hazard_unit #(
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              stall,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              mem_to_mem,
    output logic [CNT_W-1:0]  stall_cnt
);

    // EX slot keeps the full instruction class; the MEM slot keeps only what
    // later decisions read. The WB occupant is never consulted: its forwarding
    // and mem-to-mem effects are resolved one cycle earlier from the MEM slot.
    logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [ADDR_W-1:0] ex_rd, ex_rt;
    logic              mem_valid, mem_reg_write, mem_mem_read;
    logic [ADDR_W-1:0] mem_rd;

    logic       ex_wr, mem_wr;
    logic       rs_ex, rt_ex, rs_mem, rt_mem;
    logic       hazard, issue;
    logic [1:0] fa_nxt, fb_nxt;
    logic       m2m_nxt;

    always_comb begin
        ex_wr  = ex_valid & ex_reg_write & ((ZERO_REG == 1'b0) || (ex_rd != '0));
        mem_wr = mem_valid & mem_reg_write & ((ZERO_REG == 1'b0) || (mem_rd != '0));

        rs_ex  = id_rs_used & ex_wr & (id_rs == ex_rd);
        rt_ex  = id_rt_used & ex_wr & (id_rt == ex_rd);
        rs_mem = id_rs_used & mem_wr & (id_rs == mem_rd);
        rt_mem = id_rt_used & mem_wr & (id_rt == mem_rd);

        // A store whose data alone comes from a load does not stall; the
        // value is picked up later through the mem-to-mem path.
        hazard = ex_mem_read & (rs_ex | (rt_ex & ~id_mem_write));
        stall  = id_valid & ~flush & hazard;
        issue  = id_valid & ~flush & ~hazard;

        fa_nxt = 2'b00;
        fb_nxt = 2'b00;
        if (issue) begin
            if (rs_ex)       fa_nxt = 2'b10;
            else if (rs_mem) fa_nxt = 2'b01;
            if (rt_ex)       fb_nxt = 2'b10;
            else if (rt_mem) fb_nxt = 2'b01;
        end

        m2m_nxt = ex_valid & ex_mem_write & mem_wr & mem_mem_read & (mem_rd == ex_rt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_rd         <= '0;
            ex_rt         <= '0;
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_rd        <= '0;
            forward_a     <= 2'b00;
            forward_b     <= 2'b00;
            mem_to_mem    <= 1'b0;
            stall_cnt     <= '0;
        end else if (!mem_busy) begin
            mem_valid     <= ex_valid;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            mem_rd        <= ex_rd;

            ex_valid      <= issue;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_rd         <= id_rd;
            ex_rt         <= id_rt;

            forward_a     <= fa_nxt;
            forward_b     <= fb_nxt;
            mem_to_mem    <= m2m_nxt;

            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - table vectors, directed corners and random run against a pipeline model
module tb_fwd_hazard_unit;

    localparam int AW = 4;
    localparam int CW = 4;

    typedef struct {
        logic          valid;
        logic [AW-1:0] rs, rt, rd;
        logic          rsu, rtu, rw, mr, mw;
    } instr_t;

    typedef struct {
        instr_t ins;
        logic   fl, bz;
        logic   st;
        int     fa, fb;
        logic   m2m;
        int     cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic          id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic          flush = 1'b0, mem_busy = 1'b0;
    logic          stall, mem_to_mem;
    logic [1:0]    forward_a, forward_b;
    logic [CW-1:0] stall_cnt;

    fwd_hazard_unit #(.ADDR_W(AW), .ZERO_REG(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .mem_busy(mem_busy), .stall(stall), .forward_a(forward_a),
        .forward_b(forward_b), .mem_to_mem(mem_to_mem), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference pipeline: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB occupants.
    instr_t pipe [3];
    int     m_cnt;
    logic   last_stall;

    function automatic instr_t bubble();
        instr_t r;
        r.valid = 0; r.rs = 0; r.rt = 0; r.rd = 0;
        r.rsu = 0; r.rtu = 0; r.rw = 0; r.mr = 0; r.mw = 0;
        return r;
    endfunction

    function automatic instr_t ins_add(int rd, int rs, int rt);
        instr_t r = bubble();
        r.valid = 1; r.rd = AW'(rd); r.rs = AW'(rs); r.rt = AW'(rt);
        r.rsu = 1; r.rtu = 1; r.rw = 1;
        return r;
    endfunction

    function automatic instr_t ins_lw(int rt, int base);
        instr_t r = bubble();
        r.valid = 1; r.rs = AW'(base); r.rt = AW'(rt); r.rd = AW'(rt);
        r.rsu = 1; r.rw = 1; r.mr = 1;
        return r;
    endfunction

    function automatic instr_t ins_sw(int rt, int base);
        instr_t r = bubble();
        r.valid = 1; r.rs = AW'(base); r.rt = AW'(rt);
        r.rsu = 1; r.rtu = 1; r.mw = 1;
        return r;
    endfunction

    function automatic bit writes(instr_t r);
        return r.valid && r.rw && (r.rd != 0);
    endfunction

    function automatic bit m_stall(instr_t id, logic fl);
        instr_t p = pipe[0];
        if (!id.valid || fl || !writes(p) || !p.mr) return 0;
        if (id.rsu && id.rs == p.rd) return 1;
        return id.rtu && id.rt == p.rd && !id.mw;
    endfunction

    // Where the EX occupant's operand comes from: its producer now sits in MEM or WB.
    function automatic int m_sel(logic used, logic [AW-1:0] idx);
        if (!pipe[0].valid || !used) return 0;
        if (writes(pipe[1]) && pipe[1].rd == idx) return 2;
        if (writes(pipe[2]) && pipe[2].rd == idx) return 1;
        return 0;
    endfunction

    function automatic bit m_m2m();
        return pipe[1].valid && pipe[1].mw && writes(pipe[2]) && pipe[2].mr
               && pipe[2].rd == pipe[1].rt;
    endfunction

    function automatic vec_t mk(instr_t i, bit fl, bit bz, bit st, int fa, int fb, bit m, int c);
        vec_t v;
        v.ins = i; v.fl = fl; v.bz = bz; v.st = st; v.fa = fa; v.fb = fb; v.m2m = m; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = bubble();
        m_cnt = 0;
        last_stall = 0;
    endtask

    task automatic drive(instr_t i, logic fl, logic bz);
        id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_rs_used = i.rsu; id_rt_used = i.rtu; id_reg_write = i.rw;
        id_mem_read = i.mr; id_mem_write = i.mw; flush = fl; mem_busy = bz;
    endtask

    // Entered at posedge+1; checks mid-cycle, then advances the model across the edge.
    task automatic step(input vec_t v, input bit use_tab);
        bit st;
        instr_t n0;
        drive(v.ins, v.fl, v.bz);
        #4;
        st = m_stall(v.ins, v.fl);
        chk("stall", int'(stall), int'(st));
        chk("forward_a", int'(forward_a), m_sel(pipe[0].rsu, pipe[0].rs));
        chk("forward_b", int'(forward_b), m_sel(pipe[0].rtu, pipe[0].rt));
        chk("mem_to_mem", int'(mem_to_mem), int'(m_m2m()));
        chk("stall_cnt", int'(stall_cnt), m_cnt);
        if (use_tab) begin
            chk("tab_stall", int'(stall), int'(v.st));
            chk("tab_forward_a", int'(forward_a), v.fa);
            chk("tab_forward_b", int'(forward_b), v.fb);
            chk("tab_mem_to_mem", int'(mem_to_mem), int'(v.m2m));
            chk("tab_stall_cnt", int'(stall_cnt), v.cnt);
        end
        n0 = (v.ins.valid && !v.fl && !st) ? v.ins : bubble();
        last_stall = st;
        @(posedge clk);
        #1;
        if (!v.bz) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = n0;
            if (st && m_cnt < (1 << CW) - 1) m_cnt++;
        end
    endtask

    function automatic instr_t rnd_ins();
        int k = int'($urandom_range(3));
        int a = int'($urandom_range(3));
        int b = int'($urandom_range(3));
        int c = int'($urandom_range(3));
        case (k)
            0:       return bubble();
            1:       return ins_add(a, b, c);
            2:       return ins_lw(a, b);
            default: return ins_sw(a, b);
        endcase
    endfunction

    vec_t   tab [$];
    instr_t nop, cur;
    vec_t   rv;

    initial begin
        nop = bubble();
        model_reset();
        tab.push_back(mk(ins_add(3,1,2), 0,0, 0,0,0,0,0));
        tab.push_back(mk(ins_add(5,3,4), 0,0, 0,0,0,0,0));
        tab.push_back(mk(nop,            0,0, 0,2,0,0,0));
        tab.push_back(mk(nop,            0,0, 0,0,0,0,0));
        tab.push_back(mk(ins_add(3,1,2), 0,0, 0,0,0,0,0));
        tab.push_back(mk(nop,            0,0, 0,0,0,0,0));
        tab.push_back(mk(ins_add(6,1,3), 0,0, 0,0,0,0,0));
        tab.push_back(mk(nop,            0,0, 0,0,1,0,0));
        tab.push_back(mk(ins_add(3,1,2), 0,0, 0,0,0,0,0));
        tab.push_back(mk(ins_add(3,1,2), 0,0, 0,0,0,0,0));
        tab.push_back(mk(ins_add(6,3,1), 0,0, 0,0,0,0,0));
        tab.push_back(mk(nop,            0,0, 0,2,0,0,0));
        tab.push_back(mk(nop,            0,0, 0,0,0,0,0));
        tab.push_back(mk(ins_lw(2,1),    0,0, 0,0,0,0,0));
        tab.push_back(mk(ins_add(6,2,1), 0,0, 1,0,0,0,0));
        tab.push_back(mk(ins_add(6,2,1), 0,0, 0,0,0,0,1));
        tab.push_back(mk(nop,            0,0, 0,1,0,0,1));
        tab.push_back(mk(nop,            0,0, 0,0,0,0,1));
        tab.push_back(mk(ins_lw(2,1),    0,0, 0,0,0,0,1));
        tab.push_back(mk(ins_sw(2,7),    0,0, 0,0,0,0,1));
        tab.push_back(mk(nop,            0,0, 0,0,2,0,1));
        tab.push_back(mk(nop,            0,0, 0,0,0,1,1));
        tab.push_back(mk(nop,            0,0, 0,0,0,0,1));
        tab.push_back(mk(ins_lw(7,1),    0,0, 0,0,0,0,1));
        tab.push_back(mk(ins_sw(2,7),    0,0, 1,0,0,0,1));
        tab.push_back(mk(ins_sw(2,7),    0,0, 0,0,0,0,2));
        tab.push_back(mk(nop,            0,0, 0,1,0,0,2));
        tab.push_back(mk(nop,            0,0, 0,0,0,0,2));
        tab.push_back(mk(nop,            0,0, 0,0,0,0,2));
        tab.push_back(mk(ins_add(0,1,2), 0,0, 0,0,0,0,2));
        tab.push_back(mk(ins_add(5,0,0), 0,0, 0,0,0,0,2));
        tab.push_back(mk(nop,            0,0, 0,0,0,0,2));
        tab.push_back(mk(nop,            0,0, 0,0,0,0,2));
        tab.push_back(mk(ins_lw(2,1),    0,0, 0,0,0,0,2));
        tab.push_back(mk(ins_add(6,2,1), 0,1, 1,0,0,0,2));
        tab.push_back(mk(ins_add(6,2,1), 0,1, 1,0,0,0,2));
        tab.push_back(mk(ins_add(6,2,1), 0,1, 1,0,0,0,2));
        tab.push_back(mk(ins_add(6,2,1), 0,0, 1,0,0,0,2));
        tab.push_back(mk(ins_add(6,2,1), 0,0, 0,0,0,0,3));
        tab.push_back(mk(nop,            0,0, 0,1,0,0,3));
        tab.push_back(mk(ins_lw(4,1),    0,0, 0,0,0,0,3));
        tab.push_back(mk(ins_add(6,4,1), 1,0, 0,0,0,0,3));
        tab.push_back(mk(nop,            0,0, 0,0,0,0,3));

        @(posedge clk);
        #1;
        chk("reset_stall", int'(stall), 0);
        chk("reset_forward_a", int'(forward_a), 0);
        chk("reset_forward_b", int'(forward_b), 0);
        chk("reset_mem_to_mem", int'(mem_to_mem), 0);
        chk("reset_stall_cnt", int'(stall_cnt), 0);
        rst = 1'b0;

        foreach (tab[n]) step(tab[n], 1'b1);

        // Asynchronous reset while a forward is live and a load-use stall is asserted.
        step(mk(ins_add(2,1,1), 0,0, 0,0,0,0,0), 1'b0);
        step(mk(ins_lw(2,2),    0,0, 0,0,0,0,0), 1'b0);
        drive(ins_add(6,2,1), 1'b0, 1'b0);
        #3;
        chk("pre_rst_stall", int'(stall), 1);
        chk("pre_rst_forward_a", int'(forward_a), 2);
        chk("pre_rst_stall_cnt", int'(stall_cnt), 3);
        rst = 1'b1;
        #1;
        chk("async_rst_stall", int'(stall), 0);
        chk("async_rst_forward_a", int'(forward_a), 0);
        chk("async_rst_forward_b", int'(forward_b), 0);
        chk("async_rst_mem_to_mem", int'(mem_to_mem), 0);
        chk("async_rst_stall_cnt", int'(stall_cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        cur = bubble();
        for (int n = 0; n < 600; n++) begin
            if (!last_stall || $urandom_range(3) == 0) cur = rnd_ins();
            rv = mk(cur, $urandom_range(9) == 0, $urandom_range(6) == 0, 0, 0, 0, 0, 0);
            step(rv, 1'b0);
        end
        chk("random_cnt_saturated", int'(stall_cnt), m_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
